// File: rtl/dbg_guv_pkg.sv
// dbg_guv_pkg: shared widths and assembler state type for the debug governor
package dbg_guv_pkg;
   localparam int CMD_WIDTH     = 32;
   localparam int BYTE_WIDTH    = 8;
   localparam int BYTES_PER_CMD = 4;
   typedef enum logic [0:0] {ASM_IDLE, ASM_ASSEMBLE} asm_state_t;
endpackage

// File: rtl/dbg_sat_counter.sv
// dbg_sat_counter: up-counter that sticks at all-ones instead of wrapping
module dbg_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/dbg_cmd_assembler.sv
// dbg_cmd_assembler: packs host bytes MSB-first into 32-bit commands, discarding stale partial words
module dbg_cmd_assembler
   import dbg_guv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BYTE_WIDTH-1:0] byte_in_TDATA,
   input  logic                  byte_in_TVALID,
   output logic                  byte_in_TREADY,
   output logic [CMD_WIDTH-1:0]  cmd_out_TDATA,
   output logic                  cmd_out_TVALID,
   input  logic                  cmd_out_TREADY,
   input  logic                  flush,
   output logic                  timeout_pulse,
   output logic [CNT_WIDTH-1:0]  words_accepted,
   output logic [CNT_WIDTH-1:0]  words_dropped
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = CMD_WIDTH - BYTE_WIDTH;
   asm_state_t state, state_n;
   logic [1:0] cnt, cnt_n;
   logic [SW-1:0] shreg, shreg_n;
   logic [TW-1:0] tmo, tmo_n;
   logic in_asm, accept, drain, flush_d, expire, load;
   // only the 4th byte can stall, and only while the output slot is full and not draining
   assign byte_in_TREADY = !rst && !(cnt == 2'(BYTES_PER_CMD - 1) && cmd_out_TVALID && !cmd_out_TREADY);
   assign in_asm  = state == ASM_ASSEMBLE;
   assign accept  = byte_in_TVALID && byte_in_TREADY;
   assign drain   = cmd_out_TVALID && cmd_out_TREADY;
   assign flush_d = in_asm && flush;
   assign expire  = in_asm && !flush && !byte_in_TVALID && tmo == TW'(TIMEOUT_CYCLES - 1);
   assign load    = accept && !flush_d && cnt == 2'(BYTES_PER_CMD - 1);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      tmo_n   = in_asm ? tmo : '0;
      if (flush_d || expire) begin
         state_n = ASM_IDLE;
         cnt_n   = '0;
         shreg_n = '0;
         tmo_n   = '0;
      end else if (accept) begin
         state_n = load ? ASM_IDLE : ASM_ASSEMBLE;
         cnt_n   = cnt + 2'd1;
         shreg_n = load ? '0 : {shreg[SW-BYTE_WIDTH-1:0], byte_in_TDATA};
         tmo_n   = '0;
      end else if (in_asm && !byte_in_TVALID) begin
         tmo_n   = tmo + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state          <= ASM_IDLE;
         cnt            <= '0;
         shreg          <= '0;
         tmo            <= '0;
         cmd_out_TDATA  <= '0;
         cmd_out_TVALID <= 1'b0;
         timeout_pulse  <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         shreg          <= shreg_n;
         tmo            <= tmo_n;
         cmd_out_TDATA  <= load ? {shreg, byte_in_TDATA} : cmd_out_TDATA;
         cmd_out_TVALID <= load || (cmd_out_TVALID && !cmd_out_TREADY);
         timeout_pulse  <= expire;
      end
   dbg_sat_counter #(.WIDTH(CNT_WIDTH)) u_acc (
      .clk(clk), .rst(rst), .inc(drain), .count(words_accepted)
   );
   dbg_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop (
      .clk(clk), .rst(rst), .inc(flush_d || expire), .count(words_dropped)
   );
endmodule

// File: tb/tb_dbg_cmd_assembler.sv
// tb_dbg_cmd_assembler: table, directed and random checks against a queue-based byte-packing model
module tb_dbg_cmd_assembler;
   localparam int T = 16;
   logic clk = 0, rst = 1;
   logic [7:0] byte_in_TDATA = 0;
   logic byte_in_TVALID = 0, cmd_out_TREADY = 0, flush = 0;
   logic byte_in_TREADY, cmd_out_TVALID, timeout_pulse;
   logic [31:0] cmd_out_TDATA;
   logic [15:0] words_accepted, words_dropped;
   logic s_ready, s_valid, s_pulse;
   logic [31:0] s_data;
   logic [1:0] s_acc, s_drop;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   dbg_cmd_assembler #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .byte_in_TDATA(byte_in_TDATA), .byte_in_TVALID(byte_in_TVALID),
      .byte_in_TREADY(byte_in_TREADY), .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID),
      .cmd_out_TREADY(cmd_out_TREADY), .flush(flush), .timeout_pulse(timeout_pulse),
      .words_accepted(words_accepted), .words_dropped(words_dropped)
   );
   dbg_cmd_assembler #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(2)) dut_s (
      .clk(clk), .rst(rst), .byte_in_TDATA(byte_in_TDATA), .byte_in_TVALID(byte_in_TVALID),
      .byte_in_TREADY(s_ready), .cmd_out_TDATA(s_data), .cmd_out_TVALID(s_valid),
      .cmd_out_TREADY(cmd_out_TREADY), .flush(flush), .timeout_pulse(s_pulse),
      .words_accepted(s_acc), .words_dropped(s_drop)
   );

   logic [7:0] part[$];
   int m_idle, m_acc, m_drop;
   logic m_ov, m_pulse;
   logic [31:0] m_od;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      part.delete();
      m_idle = 0; m_acc = 0; m_drop = 0; m_ov = 0; m_pulse = 0; m_od = 0;
   endfunction

   function automatic logic m_ready(input logic rdy);
      return !(part.size() == 3 && m_ov && !rdy);
   endfunction

   function automatic void m_step(input logic v, input logic [7:0] d, input logic fl, input logic rdy);
      logic take, loaded;
      take = v && m_ready(rdy);
      loaded = 0;
      m_pulse = 0;
      if (m_ov && rdy) m_acc++;
      if (part.size() > 0 && fl) begin
         m_drop++; part.delete(); m_idle = 0;
      end else if (take) begin
         part.push_back(d); m_idle = 0;
         if (part.size() == 4) begin
            m_od = {part[0], part[1], part[2], part[3]};
            loaded = 1;
            part.delete();
         end
      end else if (part.size() > 0 && !v) begin
         m_idle++;
         if (m_idle == T) begin
            m_drop++; part.delete(); m_idle = 0; m_pulse = 1;
         end
      end
      m_ov = loaded || (m_ov && !rdy);
   endfunction

   function automatic int sat3(input int x);
      return x > 3 ? 3 : x;
   endfunction

   task automatic cycle(input logic v, input logic [7:0] d, input logic fl, input logic rdy);
      byte_in_TVALID = v; byte_in_TDATA = d; flush = fl; cmd_out_TREADY = rdy;
      #1;
      chk("ready", byte_in_TREADY, m_ready(rdy));
      m_step(v, d, fl, rdy);
      @(posedge clk);
      #1;
      chk("valid", cmd_out_TVALID, m_ov);
      chk("data", cmd_out_TDATA, m_od);
      chk("pulse", timeout_pulse, m_pulse);
      chk("accepted", words_accepted, m_acc);
      chk("dropped", words_dropped, m_drop);
      chk("sat_acc", s_acc, sat3(m_acc));
      chk("sat_drop", s_drop, sat3(m_drop));
   endtask

   typedef struct {
      logic v; logic [7:0] d; logic fl; logic rdy;
      logic ev; logic [31:0] ed; logic ep; int acc; int drop;
   } vec_t;
   vec_t tbl[11];

   initial begin
      tbl = '{
         '{1, 8'hDE, 0, 1, 0, 32'h0,        0, 0, 0},
         '{1, 8'hAD, 0, 1, 0, 32'h0,        0, 0, 0},
         '{1, 8'hBE, 0, 1, 0, 32'h0,        0, 0, 0},
         '{1, 8'hEF, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0},
         '{0, 8'h00, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0},
         '{1, 8'h11, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0},
         '{1, 8'h22, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0},
         '{1, 8'h33, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0},
         '{1, 8'h44, 1, 1, 0, 32'hDEADBEEF, 0, 1, 1},
         '{0, 8'h00, 0, 1, 0, 32'hDEADBEEF, 0, 1, 1},
         '{0, 8'h00, 1, 1, 0, 32'hDEADBEEF, 0, 1, 1}
      };
      m_reset();
      #2;
      chk("rst_ready", byte_in_TREADY, 0);
      chk("rst_valid", cmd_out_TVALID, 0);
      chk("rst_data", cmd_out_TDATA, 0);
      chk("rst_pulse", timeout_pulse, 0);
      chk("rst_acc", words_accepted, 0);
      chk("rst_drop", words_dropped, 0);
      @(posedge clk); @(posedge clk);
      #3 rst = 0;
      #1 chk("post_rst_ready", byte_in_TREADY, 1);

      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), cmd_out_TVALID, tbl[i].ev);
         chk($sformatf("tbl%0d_data", i), cmd_out_TDATA, tbl[i].ed);
         chk($sformatf("tbl%0d_pulse", i), timeout_pulse, tbl[i].ep);
         chk($sformatf("tbl%0d_acc", i), words_accepted, tbl[i].acc);
         chk($sformatf("tbl%0d_drop", i), words_dropped, tbl[i].drop);
      end

      // backpressure: first word held, 8th byte stalls until the slot drains
      for (int i = 1; i <= 7; i++) cycle(1, 8'(i), 0, 0);
      chk("bp_hold", cmd_out_TDATA, 32'h01020304);
      cycle(1, 8'h08, 0, 0);
      cycle(1, 8'h08, 0, 0);
      chk("bp_stall", byte_in_TREADY, 0);
      chk("bp_hold2", cmd_out_TDATA, 32'h01020304);
      cycle(1, 8'h08, 0, 1);
      chk("bp_word2", cmd_out_TDATA, 32'h05060708);
      chk("bp_valid2", cmd_out_TVALID, 1);
      cycle(0, 8'h00, 0, 1);
      chk("bp_acc", words_accepted, 3);

      // timeout after exactly T idle cycles
      cycle(1, 8'hAA, 0, 1);
      cycle(1, 8'hBB, 0, 1);
      for (int i = 0; i < T - 1; i++) cycle(0, 8'h00, 0, 1);
      chk("to_early", timeout_pulse, 0);
      cycle(0, 8'h00, 0, 1);
      chk("to_pulse", timeout_pulse, 1);
      chk("to_drop", words_dropped, 2);
      cycle(1, 8'h11, 0, 1);
      chk("to_pulse_once", timeout_pulse, 0);
      cycle(1, 8'h22, 0, 1);
      cycle(1, 8'h33, 0, 1);
      cycle(1, 8'h44, 0, 1);
      chk("to_word", cmd_out_TDATA, 32'h11223344);

      // byte on the expiry cycle wins
      cycle(1, 8'hAA, 0, 1);
      for (int i = 0; i < T - 1; i++) cycle(0, 8'h00, 0, 1);
      cycle(1, 8'hBB, 0, 1);
      chk("nt_pulse", timeout_pulse, 0);
      cycle(1, 8'hCC, 0, 1);
      cycle(1, 8'hDD, 0, 1);
      chk("nt_word", cmd_out_TDATA, 32'hAABBCCDD);
      chk("nt_drop", words_dropped, 2);

      // random traffic: busy blocks and sparse blocks that provoke timeouts
      for (int b = 0; b < 8; b++) begin
         int pv = b[0] ? 6 : 75;
         for (int i = 0; i < 120; i++)
            cycle($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1);
      end

      // async reset while a word is held and another is partial
      m_reset();
      #2 rst = 1;
      #1 rst = 0;
      #1;
      m_reset();
      for (int i = 0; i < 6; i++) cycle(1, 8'(i + 8'h40), 0, 0);
      chk("ar_hold", cmd_out_TVALID, 1);
      #2 rst = 1;
      #1;
      chk("ar_ready", byte_in_TREADY, 0);
      chk("ar_valid", cmd_out_TVALID, 0);
      chk("ar_data", cmd_out_TDATA, 0);
      chk("ar_pulse", timeout_pulse, 0);
      chk("ar_acc", words_accepted, 0);
      chk("ar_drop", words_dropped, 0);
      @(posedge clk);
      #3 rst = 0;
      m_reset();
      cycle(1, 8'h12, 0, 1);
      cycle(1, 8'h34, 0, 1);
      cycle(1, 8'h56, 0, 1);
      cycle(1, 8'h78, 0, 1);
      chk("ar_word", cmd_out_TDATA, 32'h12345678);
      cycle(0, 8'h00, 0, 1);
      chk("ar_acc1", words_accepted, 1);
      chk("ar_drop0", words_dropped, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
